baud_tick_gen: RTL
==================

// Module: baud_tick_gen
// PURPOSE
// Runtime-programmable fractional baud tick generator for the terminal serial path (UART TX/RX).
// A phase accumulator (NCO) produces an oversample tick and a bit tick, so no per-rate divider
// table is needed and the long-term rate error is bounded by the accumulator resolution.
// Rate changes are validated and applied glitch-free on a bit boundary. Supports 300..921600 baud.
// PARAMETERS
// CLK_FREQ    25_000_000  input clock frequency, Hz
// OVERSAMPLE  16          oversample ticks per bit; power of 2, 4..16
// ACC_W       24          accumulator width; fractional resolution is 2^-ACC_W of one oversample tick
// PORTS
// clk          in   1      system clock
// reset        in   1      synchronous, active-high reset
// baud_rate    in   20     requested rate in baud; 0 = stop
// baud_load    in   1      1-cycle strobe: sample baud_rate as a new request
// sync         in   1      1-cycle strobe: restart tick phase (RX start-bit alignment)
// tick_os      out  1      1-cycle pulse at OVERSAMPLE x baud
// tick_bit     out  1      1-cycle pulse at baud; always coincides with a tick_os
// cfg_ack      out  1      1-cycle pulse when a request takes effect
// cfg_error    out  1      1-cycle pulse when a request is rejected
// cfg_pending  out  1      a validated request is waiting for a bit boundary
// active_rate  out  20     rate currently in effect; 0 = stopped
// BEHAVIOUR
// Single clock domain. One clock; reset is synchronous and active-high.
// - Reset: acc=0, os_cnt=0, inc=0, pending cleared, every output 0. Reset overrides all other inputs.
// - Valid rates: 0,300,600,1200,2400,4800,9600,19200,38400,57600,115200,230400,460800,921600.
//   Any other rate, or any rate with rate*OVERSAMPLE >= CLK_FREQ, is invalid.
// - Increment per rate: inc = (rate*OVERSAMPLE*2^ACC_W + CLK_FREQ/2) / CLK_FREQ, rounded to nearest.
//   Evaluate it at elaboration in 64-bit constant arithmetic. No runtime divider.
// - NCO, every cycle while inc!=0: {carry,acc} <= acc + inc, computed in ACC_W+1 bits.
//   On carry, tick_os=1 in the next cycle.
//   os_cnt (log2 OVERSAMPLE bits) increments on each carry and wraps at OVERSAMPLE-1.
//   tick_bit=1 together with the tick_os whose carry wrapped os_cnt to 0.
// - Load, when the stream is idle (inc==0): a valid request at cycle N sets inc and active_rate
//   at the N/N+1 edge. cfg_ack=1 in cycle N+1. acc and os_cnt restart from 0.
// - Load, when the stream is running: a valid request is latched as pending and cfg_pending=1.
//   It is applied on the cycle tick_bit=1. The new inc is used from the next cycle. acc is not cleared.
//   cfg_ack=1 and cfg_pending=0 one cycle after that tick_bit.
//   A newer valid load while pending overwrites the pending request. Only the last one is acked.
// - Rate 0 applied: inc=0, acc=0, os_cnt=0, active_rate=0, ticks stop. A pending request is discarded.
// - Invalid request: cfg_error=1 in cycle N+1. The current rate and any pending request are unchanged.
// - sync: acc<=0 and os_cnt<=0, and no tick can be produced by the carry from that cycle.
//   Pending state is unaffected. sync while idle has no effect.
// - Simultaneous sync and tick_bit boundary: a pending request is still applied, and the phase is cleared.
// - Simultaneous baud_load and sync: both take effect. An idle-path load already restarts the phase.
// - Tick spacing: tick_os intervals are floor or ceil of CLK_FREQ/(rate*OVERSAMPLE) cycles.
//   Accumulated drift stays < 1 cycle over any window, beyond the inc rounding error.
// TESTING
// T1 reset, load 9600: inc=103079, cfg_ack at N+1. tick_os gaps are 162/163 cycles.
//    tick_bit gaps are 2604/2605 cycles. Mean over 64 bits = 2604.17+/-0.05.
// T2 load 115200 from idle: inc=1236951. tick_os gaps are 13/14 cycles.
//    Every 16th tick_os carries tick_bit.
// T3 running at 9600, load 19200 mid-bit: cfg_pending=1 until the next tick_bit, then cfg_ack.
//    Subsequent bit gaps are 1302/1303 cycles. No short or double tick at the switch.
// T4 load 12345, then 1000000: cfg_error pulses each time. active_rate stays 9600. Tick spacing is unchanged.
// T5 running, assert sync: the next tick_os is exactly 162/163 cycles later. os_cnt restarts.
//    The next tick_bit comes at the 16th tick_os after sync.
// T6 reset asserted mid-stream with a request pending: all outputs 0 the next cycle. No ticks until a new load.
//    Load 0 while running: ticks stop at the next bit boundary and active_rate=0.

Source files
------------

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//
// Runtime-programmable fractional baud tick generator for the terminal serial
// path. A phase accumulator (NCO) adds a rate-dependent increment every clock.
// Each carry out of the accumulator is one oversample tick. Every OVERSAMPLE-th
// oversample tick is also a bit tick. The increment for every supported rate
// is computed at elaboration, so no runtime divider is needed. The long-term
// rate error is bounded by the accumulator resolution.
//
// Rate requests are checked against the list of supported rates. While the
// generator is stopped, a valid request takes effect at once. While it is
// running, the request waits for the next bit boundary, so a character in
// flight never sees a short or doubled bit.
//
// Parameters
//   CLK_FREQ    input clock frequency in Hz
//   OVERSAMPLE  oversample ticks per bit (power of 2, 4..16)
//   ACC_W       accumulator width; resolution is 2^-ACC_W of one oversample tick
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   baud_rate    requested rate in baud (0 = stop)
//   baud_load    1-cycle strobe: sample baud_rate as a new request
//   sync         1-cycle strobe: restart the tick phase (RX start-bit alignment)
//   tick_os      1-cycle pulse at OVERSAMPLE x baud
//   tick_bit     1-cycle pulse at baud, always together with a tick_os
//   cfg_ack      1-cycle pulse when a request takes effect
//   cfg_error    1-cycle pulse when a request is rejected
//   cfg_pending  a validated request is waiting for a bit boundary
//   active_rate  rate currently in effect (0 = stopped)
// ---------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] baud_rate,
  input  logic        baud_load,
  input  logic        sync,
  output logic        tick_os,
  output logic        tick_bit,
  output logic        cfg_ack,
  output logic        cfg_error,
  output logic        cfg_pending,
  output logic [19:0] active_rate
);

  localparam int unsigned OS_W      = $clog2(OVERSAMPLE);
  localparam int          NUM_RATES = 14;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  // The supported rates. Index 0 is the "stop" request.
  function automatic longint unsigned std_rate(input int idx);
    case (idx)
      0:       return 64'd0;
      1:       return 64'd300;
      2:       return 64'd600;
      3:       return 64'd1200;
      4:       return 64'd2400;
      5:       return 64'd4800;
      6:       return 64'd9600;
      7:       return 64'd19200;
      8:       return 64'd38400;
      9:       return 64'd57600;
      10:      return 64'd115200;
      11:      return 64'd230400;
      12:      return 64'd460800;
      13:      return 64'd921600;
      default: return 64'd0;
    endcase
  endfunction

  // Rounded-to-nearest phase increment for a rate. Used only on constants.
  function automatic longint unsigned calc_inc(input longint unsigned rate);
    longint unsigned num;
    num = rate * 64'(OVERSAMPLE) * (64'd1 << ACC_W);
    return (num + 64'(CLK_FREQ) / 64'd2) / 64'(CLK_FREQ);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PEND
  } state_t;

  state_t state, state_next;

  logic [NUM_RATES-1:0] rate_hit;
  logic [ACC_W-1:0]     rate_inc [NUM_RATES];

  logic             req_valid;
  logic [ACC_W-1:0] req_inc;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [OS_W-1:0]  os_cnt;
  logic [ACC_W-1:0] pend_inc;
  logic [19:0]      pend_rate;

  logic             load_ok;
  logic             load_bad;
  logic             running;
  logic             take_direct;
  logic             apply_now;
  logic             stop_now;
  logic             phase_clear;
  logic [ACC_W-1:0] new_inc;
  logic [19:0]      new_rate;
  logic [ACC_W:0]   sum;
  logic             carry;

  // One comparator per supported rate. A rate whose oversample frequency
  // reaches the clock frequency cannot be generated and never matches.
  for (genvar i = 0; i < NUM_RATES; i++) begin : g_rate
    localparam longint unsigned RATE   = std_rate(i);
    localparam bit              USABLE = (RATE * 64'(OVERSAMPLE)) < 64'(CLK_FREQ);
    localparam longint unsigned INC    = calc_inc(RATE);
    assign rate_hit[i] = USABLE && (baud_rate == RATE[19:0]);
    assign rate_inc[i] = INC[ACC_W-1:0];
  end

  // Rates are distinct, so at most one comparator hits and OR-ing the
  // increments selects the matching one.
  always_comb begin
    req_valid = 1'b0;
    req_inc   = '0;
    for (int i = 0; i < NUM_RATES; i++) begin
      if (rate_hit[i]) begin
        req_valid = 1'b1;
        req_inc   = req_inc | rate_inc[i];
      end
    end
  end

  // Request handling and accumulator arithmetic. A load that arrives on the
  // same cycle as a pending switch replaces the pending request, because it
  // is the newest request.
  always_comb begin
    load_ok     = baud_load && req_valid;
    load_bad    = baud_load && !req_valid;
    running     = (state != ST_IDLE);
    take_direct = (state == ST_IDLE) && load_ok;
    apply_now   = (state == ST_PEND) && tick_bit;
    new_inc     = load_ok ? req_inc : pend_inc;
    new_rate    = load_ok ? baud_rate : pend_rate;
    stop_now    = apply_now && (new_inc == '0);
    phase_clear = sync || stop_now;
    sum         = {1'b0, acc} + {1'b0, inc};
    carry       = sum[ACC_W];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. IDLE always means the increment is zero. A request is
  // held in PEND until the bit boundary. Applying rate 0 returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load_ok && (req_inc != '0)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_ok) begin
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (apply_now) begin
          state_next = (new_inc == '0) ? ST_IDLE : ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic derived from the state.
  always_comb begin
    cfg_pending = (state == ST_PEND);
  end

  // NCO datapath and the registered pulse outputs. A bit tick is the carry
  // that wraps os_cnt back to 0. On sync or a stop, the carry of that cycle
  // is dropped so that no tick leaks out of the old phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      inc         <= '0;
      os_cnt      <= '0;
      pend_inc    <= '0;
      pend_rate   <= '0;
      active_rate <= '0;
      tick_os     <= 1'b0;
      tick_bit    <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      tick_os   <= 1'b0;
      tick_bit  <= 1'b0;
      cfg_ack   <= take_direct || apply_now;
      cfg_error <= load_bad;

      if (take_direct || apply_now) begin
        inc         <= new_inc;
        active_rate <= new_rate;
      end

      if (load_ok && running && !apply_now) begin
        pend_inc  <= req_inc;
        pend_rate <= baud_rate;
      end

      if (take_direct) begin
        acc    <= '0;
        os_cnt <= '0;
      end else if (running) begin
        if (phase_clear) begin
          acc    <= '0;
          os_cnt <= '0;
        end else begin
          acc <= sum[ACC_W-1:0];
          if (carry) begin
            os_cnt   <= os_cnt + OS_W'(1);
            tick_os  <= 1'b1;
            tick_bit <= (os_cnt == OS_LAST);
          end
        end
      end
    end
  end

endmodule
